// File: rtl/opb_fwd_stage_if.sv
// Operand-B stage bus: ID/EX operands, forwarding sources and EX handshake.
// Latency: none (signal bundle only).
// Backpressure: in_ready/out_ready carry it; master drives the ID/EX side, slave is the stage.
interface opb_fwd_stage_if #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [5:0]        in_op;
   logic              in_funct_imm;
   logic [REG_AW-1:0] in_rt;
   logic [IMM_W-1:0]  in_imm;
   logic [DATA_W-1:0] in_regb;
   logic              exmem_wr;
   logic [REG_AW-1:0] exmem_rd;
   logic              exmem_load;
   logic [DATA_W-1:0] exmem_value;
   logic              memwb_wr;
   logic [REG_AW-1:0] memwb_rd;
   logic [DATA_W-1:0] memwb_value;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_opb;
   logic [1:0]        out_src;
   logic              stall;

   modport master (
      output in_valid, in_op, in_funct_imm, in_rt, in_imm, in_regb,
      output exmem_wr, exmem_rd, exmem_load, exmem_value,
      output memwb_wr, memwb_rd, memwb_value, out_ready,
      input  in_ready, out_valid, out_opb, out_src, stall
   );

   modport slave (
      input  in_valid, in_op, in_funct_imm, in_rt, in_imm, in_regb,
      input  exmem_wr, exmem_rd, exmem_load, exmem_value,
      input  memwb_wr, memwb_rd, memwb_value, out_ready,
      output in_ready, out_valid, out_opb, out_src, stall
   );
endinterface

// File: rtl/opb_fwd_stage.sv
// Operand-B select/forward stage for EX with load-use interlock; FWD_STATS_EN adds fwd_cnt/lu_cnt.
// Latency: 1 cycle from ID/EX transfer to out_opb; load-use hazard adds LU_STALL bubble cycles.
// Backpressure: in_ready low while stalled, on hazard, or when the output word is unaccepted.
module opb_fwd_stage #(
   parameter int DATA_W   = 32,
   parameter int IMM_W    = 16,
   parameter int REG_AW   = 5,
   parameter int LU_STALL = 1
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef FWD_STATS_EN
   output logic [31:0] fwd_cnt,
   output logic [31:0] lu_cnt,
`else
`endif
   opb_fwd_stage_if.slave bus
);
   localparam logic [5:0] OP_ALU  = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_ADDI = 6'h08;

   localparam logic [1:0] SRC_RF  = 2'b00;
   localparam logic [1:0] SRC_WB  = 2'b01;
   localparam logic [1:0] SRC_EX  = 2'b10;
   localparam logic [1:0] SRC_IMM = 2'b11;

   localparam logic [2:0] CNT_LOAD = 3'(LU_STALL - 1);

   typedef enum logic {S_RUN, S_STALL} state_t;

   state_t            r_state;
   logic [2:0]        r_cnt;
   logic              r_stall;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_opb;
   logic [1:0]        r_out_src;

   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_sel_opb;
   logic [1:0]        w_sel_src;
   logic              w_rt_nz;
   logic              w_ex_hit;
   logic              w_wb_hit;
   logic              w_hazard;
   logic              w_in_ready;
   logic              w_xfer;

   assign w_imm_ext = bus.in_funct_imm ? {{(DATA_W-IMM_W){1'b0}}, bus.in_imm}
                                       : {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};

   // r0 is hardwired zero, so it is never a forwarding target
   assign w_rt_nz  = |bus.in_rt;
   assign w_ex_hit = w_rt_nz && bus.exmem_wr && (bus.exmem_rd == bus.in_rt);
   assign w_wb_hit = w_rt_nz && bus.memwb_wr && (bus.memwb_rd == bus.in_rt);

   // A load in EX/MEM has no data yet; an ALU consumer must wait for it to reach MEM/WB
   assign w_hazard = bus.in_valid && (bus.in_op == OP_ALU) && w_ex_hit && bus.exmem_load;

   assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || bus.out_ready) && !w_hazard;
   assign w_xfer     = bus.in_valid && w_in_ready;

   // Operand B mux: immediate class, register class with forwarding, everything else zero
   always_comb begin
      w_sel_opb = '0;
      w_sel_src = SRC_IMM;
      case (bus.in_op)
         OP_LW, OP_SW, OP_ADDI: begin
            w_sel_opb = w_imm_ext;
            w_sel_src = SRC_IMM;
         end
         OP_ALU: begin
            if (w_ex_hit && !bus.exmem_load) begin
               w_sel_opb = bus.exmem_value;
               w_sel_src = SRC_EX;
            end else if (w_wb_hit) begin
               w_sel_opb = bus.memwb_value;
               w_sel_src = SRC_WB;
            end else begin
               w_sel_opb = bus.in_regb;
               w_sel_src = SRC_RF;
            end
         end
         default: begin
            w_sel_opb = '0;
            w_sel_src = SRC_IMM;
         end
      endcase
   end

   // Load-use interlock: RUN -> STALL for LU_STALL cycles, then re-evaluate the held instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_cnt   <= 3'd0;
         r_stall <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_hazard) begin
                  r_state <= S_STALL;
                  r_cnt   <= CNT_LOAD;
                  r_stall <= 1'b1;
               end
            end
            S_STALL: begin
               if (r_cnt == 3'd0) begin
                  r_state <= S_RUN;
                  r_stall <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: begin
               r_state <= S_RUN;
               r_stall <= 1'b0;
            end
         endcase
      end
   end

   // Output register: load on transfer, hold while EX is not ready, drop valid once taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_opb   <= '0;
         r_out_src   <= SRC_RF;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_opb   <= w_sel_opb;
         r_out_src   <= w_sel_src;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef FWD_STATS_EN
   // Event counters: forwarded transfers and interlock entries, free-running with wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_cnt <= 32'd0;
         lu_cnt  <= 32'd0;
      end else begin
         if (w_xfer && ((w_sel_src == SRC_WB) || (w_sel_src == SRC_EX))) begin
            fwd_cnt <= fwd_cnt + 32'd1;
         end
         if ((r_state == S_RUN) && w_hazard) begin
            lu_cnt <= lu_cnt + 32'd1;
         end
      end
   end
`else
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_opb   = r_out_opb;
   assign bus.out_src   = r_out_src;
   assign bus.stall     = r_stall;
endmodule

// File: tb/tb_opb_fwd_stage.sv
// Bench for opb_fwd_stage: directed literal cases plus randomized traffic against a behavioural model.
// Latency: model predicts each posedge from inputs seen at the preceding negedge.
// Backpressure: out_ready is driven randomly; the model tracks the held output word.
module tb_opb_fwd_stage;
   localparam int DATA_W   = 32;
   localparam int IMM_W    = 16;
   localparam int REG_AW   = 5;
   localparam int LU_STALL = 2;

   logic clk;
   logic rst_n;
`ifdef FWD_STATS_EN
   logic [31:0] fwd_cnt;
   logic [31:0] lu_cnt;
`else
`endif

   int n_pass;
   int n_total;

   opb_fwd_stage_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .REG_AW(REG_AW)) bus ();

   opb_fwd_stage #(
      .DATA_W(DATA_W), .IMM_W(IMM_W), .REG_AW(REG_AW), .LU_STALL(LU_STALL)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
`ifdef FWD_STATS_EN
      .fwd_cnt(fwd_cnt),
      .lu_cnt (lu_cnt),
`else
`endif
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference operand: what EX must see, straight from the opcode-class and forwarding rules
   task automatic ref_sel(output logic [31:0] v, output logic [1:0] s);
      logic [31:0] imm;
      if (bus.in_funct_imm) imm = 32'(bus.in_imm);
      else                  imm = 32'($signed(bus.in_imm));
      if (bus.in_op == 6'h23 || bus.in_op == 6'h2B || bus.in_op == 6'h08) begin
         v = imm; s = 2'b11;
      end else if (bus.in_op != 6'h00) begin
         v = 32'd0; s = 2'b11;
      end else if (bus.in_rt == 0) begin
         v = bus.in_regb; s = 2'b00;
      end else if (bus.exmem_wr && bus.exmem_rd == bus.in_rt && !bus.exmem_load) begin
         v = bus.exmem_value; s = 2'b10;
      end else if (bus.memwb_wr && bus.memwb_rd == bus.in_rt) begin
         v = bus.memwb_value; s = 2'b01;
      end else begin
         v = bus.in_regb; s = 2'b00;
      end
   endtask

   // Model state: expected output word, bubbles still owed, event counts
   logic        m_valid;
   logic [31:0] m_opb;
   logic [1:0]  m_src;
   int          m_bub;
   logic [31:0] m_fwd;
   logic [31:0] m_lu;

   // Compare process: check outputs every cycle, then advance the model to the next edge
   always @(negedge clk) begin
      logic        hz;
      logic        e_ready;
      logic [31:0] v;
      logic [1:0]  s;
      if (!rst_n) begin
         chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_out_opb",   bus.out_opb, 32'd0);
         chk("rst_out_src",   32'(bus.out_src), 32'd0);
         chk("rst_stall",     32'(bus.stall), 32'd0);
`ifdef FWD_STATS_EN
         chk("rst_fwd_cnt", fwd_cnt, 32'd0);
         chk("rst_lu_cnt",  lu_cnt, 32'd0);
`else
`endif
         m_valid = 1'b0; m_opb = '0; m_src = 2'b00;
         m_bub = 0; m_fwd = '0; m_lu = '0;
      end else begin
         hz = bus.in_valid && bus.in_op == 6'h00 && bus.exmem_wr && bus.exmem_load &&
              bus.exmem_rd == bus.in_rt && bus.in_rt != 0;
         e_ready = (m_bub == 0) && (!m_valid || bus.out_ready) && !hz;
         chk("in_ready",  32'(bus.in_ready), 32'(e_ready));
         chk("stall",     32'(bus.stall), 32'(m_bub != 0));
         chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("out_opb", bus.out_opb, m_opb);
            chk("out_src", 32'(bus.out_src), 32'(m_src));
         end
`ifdef FWD_STATS_EN
         chk("fwd_cnt", fwd_cnt, m_fwd);
         chk("lu_cnt",  lu_cnt, m_lu);
`else
`endif
         if (bus.in_valid && e_ready) begin
            ref_sel(v, s);
            m_valid = 1'b1; m_opb = v; m_src = s;
            if (s == 2'b01 || s == 2'b10) m_fwd = m_fwd + 32'd1;
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
         if (m_bub != 0) m_bub = m_bub - 1;
         else if (hz) begin
            m_bub = LU_STALL;
            m_lu = m_lu + 32'd1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid = 0; bus.in_op = 6'h00; bus.in_funct_imm = 0; bus.in_rt = '0;
      bus.in_imm = '0; bus.in_regb = '0;
      bus.exmem_wr = 0; bus.exmem_rd = '0; bus.exmem_load = 0; bus.exmem_value = '0;
      bus.memwb_wr = 0; bus.memwb_rd = '0; bus.memwb_value = '0;
      bus.out_ready = 1;
   endtask

   task automatic set_op(input logic [5:0] op, input logic fz, input logic [4:0] rt,
                         input logic [15:0] imm, input logic [31:0] regb);
      bus.in_valid = 1; bus.in_op = op; bus.in_funct_imm = fz;
      bus.in_rt = rt; bus.in_imm = imm; bus.in_regb = regb;
   endtask

   initial begin
      logic [5:0] ops [7];
      n_pass = 0; n_total = 0;
      ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h02, 6'h03};
      rst_n = 0;
      idle_inputs();
      #22;
      rst_n = 1;
      tick();

      // Immediate sign/zero extension
      set_op(6'h08, 0, 5'd0, 16'hFFFC, 32'h0);
      tick(); #1;
      chk("addi_sext_opb", bus.out_opb, 32'hFFFF_FFFC);
      chk("addi_sext_src", 32'(bus.out_src), 32'd3);
      bus.in_funct_imm = 1;
      tick(); #1;
      chk("addi_zext_opb", bus.out_opb, 32'h0000_FFFC);

      // Forwarding priority EX/MEM over MEM/WB, then MEM/WB alone
      set_op(6'h00, 0, 5'd5, 16'h0, 32'h33);
      bus.exmem_wr = 1; bus.exmem_rd = 5'd5; bus.exmem_value = 32'h11;
      bus.memwb_wr = 1; bus.memwb_rd = 5'd5; bus.memwb_value = 32'h22;
      tick(); #1;
      chk("fwd_ex_opb", bus.out_opb, 32'h11);
      chk("fwd_ex_src", 32'(bus.out_src), 32'd2);
      bus.exmem_wr = 0;
      tick(); #1;
      chk("fwd_wb_opb", bus.out_opb, 32'h22);
      chk("fwd_wb_src", 32'(bus.out_src), 32'd1);

      // r0 never forwarded
      set_op(6'h00, 0, 5'd0, 16'h0, 32'h0);
      bus.exmem_wr = 1; bus.exmem_rd = 5'd0; bus.exmem_value = 32'hDEAD;
      bus.memwb_wr = 0;
      tick(); #1;
      chk("r0_opb", bus.out_opb, 32'h0);
      chk("r0_src", 32'(bus.out_src), 32'd0);

      // Load-use interlock, data then arrives through MEM/WB
      set_op(6'h00, 0, 5'd7, 16'h0, 32'h55);
      bus.exmem_wr = 1; bus.exmem_rd = 5'd7; bus.exmem_load = 1;
      #1;
      chk("lu_detect_ready", 32'(bus.in_ready), 32'd0);
      tick(); #1;
      chk("lu_stall1", 32'(bus.stall), 32'd1);
      chk("lu_ready1", 32'(bus.in_ready), 32'd0);
      chk("lu_bubble", 32'(bus.out_valid), 32'd0);
      bus.exmem_wr = 0; bus.exmem_load = 0;
      bus.memwb_wr = 1; bus.memwb_rd = 5'd7; bus.memwb_value = 32'hABCD;
      tick(); #1;
      chk("lu_stall2", 32'(bus.stall), 32'd1);
      chk("lu_ready2", 32'(bus.in_ready), 32'd0);
      tick(); #1;
      chk("lu_stall_end", 32'(bus.stall), 32'd0);
      chk("lu_ready_back", 32'(bus.in_ready), 32'd1);
      tick(); #1;
      chk("lu_opb", bus.out_opb, 32'h0000_ABCD);
      chk("lu_src", 32'(bus.out_src), 32'd1);
`ifdef FWD_STATS_EN
      chk("lu_cnt_one", lu_cnt, 32'd1);
      chk("fwd_cnt_three", fwd_cnt, 32'd3);
`else
`endif

      // Output backpressure holds the word
      bus.out_ready = 0;
      set_op(6'h08, 1, 5'd0, 16'h0010, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", 32'(bus.in_ready), 32'd0);
         tick(); #1;
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_opb", bus.out_opb, 32'h0000_ABCD);
      end
      bus.out_ready = 1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
      tick(); #1;
      chk("bp_next_opb", bus.out_opb, 32'h10);
      chk("bp_next_src", 32'(bus.out_src), 32'd3);

      // Reset during STALL aborts to RUN
      set_op(6'h00, 0, 5'd7, 16'h0, 32'h0);
      bus.memwb_wr = 0;
      bus.exmem_wr = 1; bus.exmem_rd = 5'd7; bus.exmem_load = 1;
      tick(); #1;
      chk("rs_stall", 32'(bus.stall), 32'd1);
      rst_n = 0;
      #1;
      chk("rs_opb", bus.out_opb, 32'h0);
      chk("rs_stall_clr", 32'(bus.stall), 32'd0);
      chk("rs_valid", 32'(bus.out_valid), 32'd0);
      bus.exmem_wr = 0; bus.exmem_load = 0;
      set_op(6'h02, 0, 5'd3, 16'h1234, 32'h1234);
      tick();
      rst_n = 1;
      tick(); #1;
      chk("rs_j_valid", 32'(bus.out_valid), 32'd1);
      chk("rs_j_opb", bus.out_opb, 32'h0);
      chk("rs_j_src", 32'(bus.out_src), 32'd3);

      // Randomized traffic, checked by the compare process
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         bus.in_valid     = ($urandom_range(0, 3) != 0);
         bus.in_op        = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         bus.in_funct_imm = 1'($urandom);
         bus.in_rt        = 5'($urandom_range(0, 3));
         bus.in_imm       = 16'($urandom);
         bus.in_regb      = $urandom;
         bus.exmem_wr     = 1'($urandom);
         bus.exmem_rd     = 5'($urandom_range(0, 3));
         bus.exmem_load   = ($urandom_range(0, 3) == 0);
         bus.exmem_value  = $urandom;
         bus.memwb_wr     = 1'($urandom);
         bus.memwb_rd     = 5'($urandom_range(0, 3));
         bus.memwb_value  = $urandom;
         bus.out_ready    = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst_n = 1;
      idle_inputs();
      tick();
      tick();
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/opb_fwd_stage.md
Name: opb_fwd_stage

Overview:
Parametrised operand-B select stage for the EX input of the MIPS pipeline. It registers the EX operand B each cycle and chooses between the sign/zero-extended immediate, zero, and the register operand. The register operand is forwarded from EX/MEM or MEM/WB when those stages write the source register. It adds a valid/ready handshake, a configurable-width load-use interlock FSM, and N-register addressing.

Parameters:
DATA_W, 32, operand and forwarded-value width
IMM_W, 16, immediate field width (IMM_W < DATA_W)
REG_AW, 5, register index width
LU_STALL, 1, bubble cycles inserted on load-use hazard (1..7)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID/EX holds a valid instruction
in_ready  out  1  stage can accept ID/EX this cycle
in_op  in  6  primary opcode
in_funct_imm  in  1  1: zero-extend immediate (ANDI/ORI class), 0: sign-extend
in_rt  in  REG_AW  source register of operand B
in_imm  in  IMM_W  immediate field
in_regb  in  DATA_W  register-file value of rt
exmem_wr  in  1  EX/MEM writes a register
exmem_rd  in  REG_AW  EX/MEM destination
exmem_load  in  1  EX/MEM instruction is a load (value not yet valid)
exmem_value  in  DATA_W  EX/MEM ALU result
memwb_wr  in  1  MEM/WB writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_value  in  DATA_W  MEM/WB writeback value
out_valid  out  1  out_opb valid for EX
out_ready  in  1  EX accepts out_opb
out_opb  out  DATA_W  registered operand B
out_src  out  2  00 regfile, 01 MEM/WB, 10 EX/MEM, 11 imm/zero
stall  out  1  load-use interlock active

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_opb=0, out_src=00, stall=0, FSM=RUN, stall counter=0. Mid-stall reset aborts to RUN.
- Opcode classes: LW 6'h23, SW 6'h2B, ADDI 6'h08 select immediate. J 6'h02, JAL 6'h03 and any unlisted opcode select 0. ALU 6'h00 selects register operand.
- Immediate: in_funct_imm=0 gives sign-extend to DATA_W; in_funct_imm=1 gives zero-extend. Immediate and zero selections report out_src=11.
- Register operand priority:
  - EX/MEM when exmem_wr, exmem_rd==in_rt and !exmem_load;
  - else MEM/WB when memwb_wr and memwb_rd==in_rt;
  - else in_regb.
  - rt==0 never forwarded; it always selects in_regb.
- Hazard = in_valid and ALU op and exmem_wr and exmem_load and exmem_rd==in_rt and in_rt!=0.
- FSM RUN: on hazard go to STALL, load counter=LU_STALL-1, stall=1, in_ready=0, out_valid drops to 0 once EX takes the current word (bubble).
- FSM STALL: decrement counter each cycle. At 0 return to RUN and re-evaluate the same held instruction; the data now arrives via MEM/WB.
- Handshake:
  - in_ready = (state==RUN) and (!out_valid or out_ready) and no hazard.
  - Transfer when in_valid and in_ready; output registered next edge (latency 1).
  - out_opb/out_src are held stable while out_valid and !out_ready.
  - out_valid clears when EX accepts and no new transfer occurs.
- Simultaneous: EX/MEM and MEM/WB both matching picks EX/MEM. Hazard and out_ready stall in the same cycle: hazard wins and no transfer occurs.
- Widths: all compares on REG_AW bits. No arithmetic beyond the counter, which is 3 bits and saturates at 0.

Optional Feature:
FWD_STATS_EN: adds out ports fwd_cnt (32) and lu_cnt (32), reset to 0.
- fwd_cnt increments on each accepted transfer with out_src 01 or 10.
- lu_cnt increments on each RUN->STALL entry.
- Both wrap at 2^32.
Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ADDI, imm=16'hFFFC, funct_imm=0 -> next cycle out_opb=32'hFFFFFFFC, out_src=11; same with funct_imm=1 -> 32'h0000FFFC.
- ALU rt=5, exmem_wr rd=5 value=32'h11, memwb_wr rd=5 value=32'h22 -> out_opb=32'h11, out_src=10; EX/MEM off -> 32'h22, src=01.
- ALU rt=0, exmem_wr rd=0 value=32'hDEAD, in_regb=0 -> out_opb=0, src=00.
- Load-use rt=7, exmem_load rd=7, LU_STALL=2 -> stall=1 and in_ready=0 for 2 cycles. Then memwb rd=7 value=32'hABCD -> out_opb=32'hABCD; lu_cnt=1 with FWD_STATS_EN.
- out_ready=0 for 3 cycles with out_valid=1 -> out_opb stable, in_ready=0; release -> next instruction accepted.
- rst_n pulled low during STALL -> outputs 0 immediately, stall=0; after release the FSM is in RUN and accepts a J op -> out_opb=0, src=11.
